rob_commit: RTL and testbench

In-order commit stage with a reorder buffer. It allocates a tag per issued instruction, accepts result completions in any order, and retires entries strictly in program order. Retirement drives the write port (`regwrite`/`writereg`/`writedata`) of the architectural register bank. It sits between the execution units' writeback bus and the register bank, and is the writer for that bank.

---
 rtl/rob_commit_pkg.sv | 16 +
 rtl/rob_commit.sv | 98 +++++++++
 tb/tb_rob_commit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_pkg.sv
// Shared types for the reorder-buffer commit stage.
// Holds data/register widths and the ROB entry layout.
package rob_commit_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  wen;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit.sv
// In-order commit stage: allocates tags, takes out-of-order
// completions, retires head entries into the register bank.
//
// Ports:
//   clk, rst_n                       clock, sync active-low reset
//   alloc_valid/dest/wen             allocation request
//   alloc_ready, alloc_tag           free-slot flag and tail tag (comb)
//   cpl_valid/tag/data               result completion
//   regwrite, writereg, writedata    bank write port (registered)
//   count                            occupancy (registered)
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_valid,
  input  logic [REG_ADDR_W-1:0] alloc_dest,
  input  logic                  alloc_wen,
  output logic                  alloc_ready,
  output logic [TAG_W-1:0]      alloc_tag,
  input  logic                  cpl_valid,
  input  logic [TAG_W-1:0]      cpl_tag,
  input  logic [DATA_W-1:0]     cpl_data,
  output logic                  regwrite,
  output logic [REG_ADDR_W-1:0] writereg,
  output logic [DATA_W-1:0]     writedata,
  output logic [TAG_W:0]        count
);

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] ONE  = (TAG_W+1)'(1);

  rob_entry_t         q [DEPTH];
  logic [TAG_W-1:0]   head;
  logic [TAG_W-1:0]   tail;
  logic               do_alloc;
  logic               do_cpl;
  logic               do_ret;
  rob_entry_t         hd;

  assign alloc_ready = (count != FULL);
  assign alloc_tag   = tail;
  assign hd          = q[head];

  // Retire uses pre-edge done, so a completion to the head
  // entry only becomes visible to retire on the next edge.
  assign do_alloc = alloc_valid && alloc_ready;
  assign do_cpl   = cpl_valid && q[cpl_tag].valid
                    && !q[cpl_tag].done;
  assign do_ret   = hd.valid && hd.done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      regwrite  <= 1'b0;
      writereg  <= '0;
      writedata <= '0;
    end else begin
      if (do_cpl) begin
        q[cpl_tag].done <= 1'b1;
        q[cpl_tag].data <= cpl_data;
      end
      if (do_ret) begin
        q[head].valid <= 1'b0;
        q[head].done  <= 1'b0;
        head          <= head + TAG_W'(1);
      end
      // Tail and head never coincide with a live alloc and a
      // retire, so these writes never hit the same entry.
      if (do_alloc) begin
        q[tail].valid <= 1'b1;
        q[tail].done  <= 1'b0;
        q[tail].wen   <= alloc_wen;
        q[tail].dest  <= alloc_dest;
        tail          <= tail + TAG_W'(1);
      end
      unique case ({do_alloc, do_ret})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      regwrite <= do_ret && hd.wen && (hd.dest != '0);
      if (do_ret) begin
        writereg  <= hd.dest;
        writedata <= hd.data;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit.
// Hand-computed vectors, one checking task.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid;
  logic [4:0]  alloc_dest;
  logic        alloc_wen;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cpl_valid;
  logic [2:0]  cpl_tag;
  logic [31:0] cpl_data;
  logic        regwrite;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rob_commit #(.DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_valid (alloc_valid),
    .alloc_dest  (alloc_dest),
    .alloc_wen   (alloc_wen),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .cpl_valid   (cpl_valid),
    .cpl_tag     (cpl_tag),
    .cpl_data    (cpl_data),
    .regwrite    (regwrite),
    .writereg    (writereg),
    .writedata   (writedata),
    .count       (count)
  );

  // Protocol: no completion to the tag being allocated.
  always @(posedge clk) begin
    if (rst_n && alloc_valid && alloc_ready && cpl_valid)
      assert (cpl_tag != alloc_tag);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, pass the edge, return to idle.
  task automatic cyc(input logic av, input logic [4:0] ad,
                     input logic aw, input logic cv,
                     input logic [2:0] ct,
                     input logic [31:0] cd);
    alloc_valid = av;
    alloc_dest  = ad;
    alloc_wen   = aw;
    cpl_valid   = cv;
    cpl_tag     = ct;
    cpl_data    = cd;
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    cpl_valid   = 1'b0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(input logic [4:0] d, input logic w);
    cyc(1, d, w, 0, 0, 0);
  endtask

  task automatic cpl(input logic [2:0] t, input logic [31:0] d);
    cyc(0, 0, 0, 1, t, d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    alloc_valid = 1'b0;
    alloc_dest  = '0;
    alloc_wen   = 1'b0;
    cpl_valid   = 1'b0;
    cpl_tag     = '0;
    cpl_data    = '0;

    // reset and idle
    do_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(alloc_ready), 1);
    chk("rst_tag", 32'(alloc_tag), 0);
    for (int i = 0; i < 3; i++) begin
      chk("idle_rw", 32'(regwrite), 0);
      idle();
    end

    // out-of-order completion, in-order retire
    chk("tag0", 32'(alloc_tag), 0);
    alloc(5, 1);
    chk("tag1", 32'(alloc_tag), 1);
    alloc(6, 1);
    chk("tag2", 32'(alloc_tag), 2);
    alloc(7, 1);
    chk("cnt3", 32'(count), 3);
    cpl(2, 32'hC);
    chk("oo_rw_a", 32'(regwrite), 0);
    cpl(0, 32'hA);
    chk("oo_rw_b", 32'(regwrite), 0);
    chk("oo_cnt", 32'(count), 3);
    cpl(1, 32'hB);
    chk("ret0_rw", 32'(regwrite), 1);
    chk("ret0_wr", 32'(writereg), 5);
    chk("ret0_wd", writedata, 32'hA);
    chk("ret0_cnt", 32'(count), 2);
    idle();
    chk("ret1_rw", 32'(regwrite), 1);
    chk("ret1_wr", 32'(writereg), 6);
    chk("ret1_wd", writedata, 32'hB);
    idle();
    chk("ret2_rw", 32'(regwrite), 1);
    chk("ret2_wr", 32'(writereg), 7);
    chk("ret2_wd", writedata, 32'hC);
    chk("ret2_cnt", 32'(count), 0);
    idle();
    chk("post_rw", 32'(regwrite), 0);
    chk("hold_wr", 32'(writereg), 7);
    chk("hold_wd", writedata, 32'hC);

    // fill, overflow attempt, retire, wrap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc(5'(8 + i), 1);
    end
    chk("full_cnt", 32'(count), 8);
    chk("full_rdy", 32'(alloc_ready), 0);
    cyc(1, 30, 1, 1, 0, 32'h11);
    chk("ovf_cnt", 32'(count), 8);
    chk("ovf_rw", 32'(regwrite), 0);
    chk("ovf_rdy", 32'(alloc_ready), 0);
    alloc(30, 1);
    chk("fret_cnt", 32'(count), 7);
    chk("fret_rw", 32'(regwrite), 1);
    chk("fret_wr", 32'(writereg), 8);
    chk("fret_wd", writedata, 32'h11);
    chk("fret_rdy", 32'(alloc_ready), 1);
    chk("wrap_tag", 32'(alloc_tag), 0);
    alloc(20, 1);
    chk("wrap_cnt", 32'(count), 8);
    chk("wrap_rdy", 32'(alloc_ready), 0);
    chk("wrap_tag2", 32'(alloc_tag), 1);

    // dest 0, wen 0, duplicate and stray completions
    do_reset();
    alloc(0, 1);
    alloc(9, 0);
    alloc(10, 1);
    cpl(1, 32'h99);
    cpl(0, 32'h55);
    chk("z_cnt3", 32'(count), 3);
    chk("z_rw0", 32'(regwrite), 0);
    idle();
    chk("d0_rw", 32'(regwrite), 0);
    chk("d0_wr", 32'(writereg), 0);
    chk("d0_wd", writedata, 32'h55);
    chk("d0_cnt", 32'(count), 2);
    idle();
    chk("nw_rw", 32'(regwrite), 0);
    chk("nw_wr", 32'(writereg), 9);
    chk("nw_cnt", 32'(count), 1);
    cpl(2, 32'h77);
    cpl(2, 32'h88);
    chk("dup_rw", 32'(regwrite), 1);
    chk("dup_wr", 32'(writereg), 10);
    chk("dup_wd", writedata, 32'h77);
    chk("dup_cnt", 32'(count), 0);
    cpl(5, 32'hDEAD);
    chk("stray_cnt", 32'(count), 0);
    chk("stray_rw", 32'(regwrite), 0);
    chk("stray_tag", 32'(alloc_tag), 3);
    alloc(11, 1);
    cpl(3, 32'h1234);
    idle();
    chk("after_rw", 32'(regwrite), 1);
    chk("after_wr", 32'(writereg), 11);
    chk("after_wd", writedata, 32'h1234);

    // reset with pending work
    alloc(1, 1);
    alloc(2, 1);
    alloc(3, 1);
    alloc(4, 1);
    cpl(5, 32'h5);
    cpl(6, 32'h6);
    chk("pre_cnt", 32'(count), 4);
    rst_n = 1'b0;
    cyc(1, 7, 1, 1, 4, 32'h4);
    rst_n = 1'b1;
    chk("mr_cnt", 32'(count), 0);
    chk("mr_rw", 32'(regwrite), 0);
    chk("mr_wr", 32'(writereg), 0);
    chk("mr_wd", writedata, 0);
    chk("mr_rdy", 32'(alloc_ready), 1);
    chk("mr_tag", 32'(alloc_tag), 0);
    cpl(4, 32'h4);
    for (int i = 0; i < 5; i++) begin
      chk("mr_idle_rw", 32'(regwrite), 0);
      chk("mr_idle_cnt", 32'(count), 0);
      idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
